// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front-end fetch sequencer.
// Holds the sequencer state encoding, redirect type codes and the default boot address.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HOLD = 2'b10
    } pc_state_e;

    typedef enum logic [1:0] {
        REDIR_J    = 2'b00,
        REDIR_JR   = 2'b01,
        REDIR_BR   = 2'b10,
        REDIR_NONE = 2'b11
    } redir_type_e;

endpackage

// File: rtl/jump_target_gen.sv
// Combinational redirect target generator for J/JAL, JR and PC-relative branches.
// Also flags misaligned JR targets and the reserved redirect type.
module jump_target_gen
    import mips_pkg::*;
(
    input  logic [1:0]  redir_type,
    input  logic [25:0] redir_index,
    input  logic [31:0] redir_reg,
    input  logic [15:0] redir_off,
    input  logic [31:0] redir_npc,
    output logic [31:0] target,
    output logic        type_valid,
    output logic        jr_misaligned
);

    // Branch offsets are word counts, so sign-extend and scale by four; overflow wraps.
    always_comb begin
        target        = 32'h0;
        type_valid    = 1'b1;
        jr_misaligned = 1'b0;
        case (redir_type_e'(redir_type))
            REDIR_J:  target = {redir_npc[31:28], redir_index, 2'b00};
            REDIR_JR: begin
                target        = redir_reg;
                jr_misaligned = (redir_reg[1:0] != 2'b00);
            end
            REDIR_BR: target = redir_npc + {{14{redir_off[15]}}, redir_off, 2'b00};
            default:  type_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boots to RESET_PC, steps by four, and applies decode redirects,
// parking a redirect in a one-entry buffer while instruction memory is not ready.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        if_ready,
    input  logic        redir_valid,
    input  logic [1:0]  redir_type,
    input  logic [25:0] redir_index,
    input  logic [31:0] redir_reg,
    input  logic [15:0] redir_off,
    input  logic [31:0] redir_npc,
    output logic        fetch_valid,
    output logic [31:0] pc,
    output logic [31:0] npc,
    output logic [31:0] link,
    output logic        misalign
);

    pc_state_e   state;
    logic [31:0] target_buf;
    logic [31:0] target;
    logic        type_valid;
    logic        jr_misaligned;
    logic        redir_req;

    jump_target_gen u_target_gen (
        .redir_type    (redir_type),
        .redir_index   (redir_index),
        .redir_reg     (redir_reg),
        .redir_off     (redir_off),
        .redir_npc     (redir_npc),
        .target        (target),
        .type_valid    (type_valid),
        .jr_misaligned (jr_misaligned)
    );

    assign redir_req = redir_valid && type_valid;
    assign npc       = pc + 32'd4;
    assign link      = redir_npc + 32'd4;

    // Redirects outrank both stall and sequential stepping; a rejected JR freezes the PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
            target_buf  <= 32'h0;
        end else begin
            misalign <= 1'b0;
            case (state)
                S_BOOT: begin
                    state       <= S_RUN;
                    pc          <= RESET_PC;
                    fetch_valid <= 1'b1;
                end
                S_RUN: begin
                    if (redir_req && jr_misaligned) begin
                        misalign <= 1'b1;
                    end else if (redir_req) begin
                        if (if_ready) begin
                            pc <= target;
                        end else begin
                            target_buf <= target;
                            state      <= S_HOLD;
                        end
                    end else if (if_ready && !stall) begin
                        pc <= pc + 32'd4;
                    end
                end
                S_HOLD: begin
                    if (if_ready) begin
                        pc    <= target_buf;
                        state <= S_RUN;
                    end
                end
                default: begin
                    state       <= S_BOOT;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: boot, J/branch/JR redirects, hold buffer,
// misaligned JR rejection, stall, wrap-around and asynchronous reset while holding.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        if_ready;
    logic        redir_valid;
    logic [1:0]  redir_type;
    logic [25:0] redir_index;
    logic [31:0] redir_reg;
    logic [15:0] redir_off;
    logic [31:0] redir_npc;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] link;
    logic        misalign;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .if_ready    (if_ready),
        .redir_valid (redir_valid),
        .redir_type  (redir_type),
        .redir_index (redir_index),
        .redir_reg   (redir_reg),
        .redir_off   (redir_off),
        .redir_npc   (redir_npc),
        .fetch_valid (fetch_valid),
        .pc          (pc),
        .npc         (npc),
        .link        (link),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic rdy, input logic rv, input logic [1:0] rt,
                                 input logic [25:0] idx, input logic [31:0] rreg,
                                 input logic [15:0] off, input logic [31:0] rnpc);
        stall       = s;
        if_ready    = rdy;
        redir_valid = rv;
        redir_type  = rt;
        redir_index = idx;
        redir_reg   = rreg;
        redir_off   = off;
        redir_npc   = rnpc;
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        stepCycle();
        checkOutput("reset_pc", pc, 32'h0000_3000);
        checkOutput("reset_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
        checkOutput("reset_npc", npc, 32'h0000_3004);

        rst_n = 1'b1;
        #2;
        checkOutput("boot_fetch_valid", {31'b0, fetch_valid}, 32'h0);
        stepCycle();
        checkOutput("boot_run_fetch_valid", {31'b0, fetch_valid}, 32'h1);
        checkOutput("boot_pc0", pc, 32'h0000_3000);
        stepCycle();
        checkOutput("boot_pc1", pc, 32'h0000_3004);
        stepCycle();
        checkOutput("boot_pc2", pc, 32'h0000_3008);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 26'h0000_100, 32'h0, 16'h0, 32'h4000_3010);
        #1;
        checkOutput("jal_link", link, 32'h4000_3014);
        stepCycle();
        checkOutput("j_target", pc, 32'h4000_0400);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0, 16'hFFFC, 32'h0000_3010);
        stepCycle();
        checkOutput("branch_back", pc, 32'h0000_3000);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0, 16'h7FFF, 32'h0000_3010);
        stepCycle();
        checkOutput("branch_max_fwd", pc, 32'h0002_300C);

        applyStimulus(1'b1, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        checkOutput("stall_rdy_pc", pc, 32'h0002_300C);
        applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        checkOutput("stall_nrdy_pc", pc, 32'h0002_300C);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0, 16'hFFFC, 32'h0000_3010);
        stepCycle();
        checkOutput("redir_over_stall", pc, 32'h0000_3000);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b11, 26'h3FF_FFFF, 32'h0000_9000, 16'h0010, 32'h0000_5000);
        stepCycle();
        checkOutput("reserved_type_seq", pc, 32'h0000_3004);

        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 26'h0, 32'h0000_3100, 16'h0, 32'h0);
        stepCycle();
        checkOutput("hold_pc_c1", pc, 32'h0000_3004);
        checkOutput("hold_fetch_valid", {31'b0, fetch_valid}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 26'h0000_200, 32'h0, 16'h0, 32'h0000_3010);
        stepCycle();
        checkOutput("hold_pc_c2", pc, 32'h0000_3004);
        stepCycle();
        checkOutput("hold_pc_c3", pc, 32'h0000_3004);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 26'h0000_200, 32'h0, 16'h0, 32'h0000_3010);
        stepCycle();
        checkOutput("hold_release", pc, 32'h0000_3100);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        checkOutput("post_hold_seq", pc, 32'h0000_3104);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 26'h0, 32'h0000_3102, 16'h0, 32'h0);
        stepCycle();
        checkOutput("misalign_pulse", {31'b0, misalign}, 32'h1);
        checkOutput("misalign_pc", pc, 32'h0000_3104);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        checkOutput("misalign_clear", {31'b0, misalign}, 32'h0);
        checkOutput("misalign_resume", pc, 32'h0000_3108);

        applyStimulus(1'b0, 1'b1, 1'b1, 2'b10, 26'h0, 32'h0, 16'h0008, 32'hFFFF_FFF0);
        stepCycle();
        checkOutput("branch_wrap", pc, 32'h0000_0010);
        applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 26'h0, 32'hFFFF_FFFC, 16'h0, 32'h0);
        stepCycle();
        checkOutput("jr_top", pc, 32'hFFFF_FFFC);
        checkOutput("npc_wrap", npc, 32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        checkOutput("pc_wrap", pc, 32'h0000_0000);

        applyStimulus(1'b0, 1'b0, 1'b1, 2'b01, 26'h0, 32'h0000_3200, 16'h0, 32'h0);
        stepCycle();
        checkOutput("hold2_pc", pc, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pc", pc, 32'h0000_3000);
        checkOutput("async_reset_fv", {31'b0, fetch_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 26'h0, 32'h0, 16'h0, 32'h0);
        stepCycle();
        rst_n = 1'b1;
        stepCycle();
        checkOutput("reboot_pc", pc, 32'h0000_3000);
        stepCycle();
        checkOutput("reboot_no_buffer", pc, 32'h0000_3004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, address of the first instruction fetched after reset.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; PC holds.
- if_ready  in  1  instruction memory accepts the current fetch address.
- redir_valid  in  1  redirect request from decode.
- redir_type  in  2  00 = J/JAL index, 01 = JR register, 10 = branch offset, 11 = reserved.
- redir_index  in  26  J/JAL instruction index.
- redir_reg  in  32  JR target.
- redir_off  in  16  branch offset, in words, signed.
- redir_npc  in  32  PC+4 of the redirecting instruction.
- fetch_valid  out  1  pc is a valid fetch address.
- pc  out  32  current fetch address.
- npc  out  32  pc+4.
- link  out  32  redir_npc+4, for JAL.
- misalign  out  1  one-cycle pulse on a rejected JR target.

Function
REQ-003 States SHALL be S_BOOT, S_RUN and S_HOLD; reset enters S_BOOT.
REQ-004 S_BOOT SHALL last exactly one cycle with fetch_valid=0, then go to S_RUN with pc=RESET_PC.
REQ-005 In S_RUN, fetch_valid SHALL be 1; pc SHALL advance to pc+4 only on a cycle with if_ready=1, stall=0 and no redirect.
REQ-006 Targets SHALL be computed as follows:
- J: {redir_npc[31:28], redir_index, 2'b00}.
- JR: redir_reg.
- Branch: redir_npc + (sign-extended redir_off << 2).
- All arithmetic 32-bit, modulo 2^32; wrap-around is silent.
REQ-007 A redirect accepted in S_RUN with if_ready=1 SHALL load the target into pc on the next edge; redirect takes priority over sequential increment and over stall.
REQ-008 A redirect with if_ready=0 SHALL latch the target into a one-entry buffer and enter S_HOLD; pc is unchanged.
REQ-009 In S_HOLD, redir_valid SHALL be ignored; when if_ready=1, pc SHALL load the buffered target and the state returns to S_RUN.
REQ-010 fetch_valid SHALL stay 1 in S_HOLD; pc keeps the old address until the buffer is consumed.
REQ-011 A JR target with redir_reg[1:0]!=0 SHALL be rejected:
- pc is unchanged and the state is unchanged.
- misalign pulses high for one cycle.
REQ-012 redir_type=11 SHALL be treated as no redirect.
REQ-013 link SHALL be combinational redir_npc+4; npc SHALL be combinational pc+4.
REQ-014 stall=1 without a redirect SHALL hold pc regardless of if_ready.
REQ-015 Latency from an accepted redirect to the target appearing on pc SHALL be exactly 1 cycle in S_RUN.

Reset
REQ-016 rst_n low SHALL act asynchronously, including mid-S_HOLD, and SHALL set:
- state to S_BOOT.
- pc to RESET_PC.
- fetch_valid to 0 and misalign to 0.
- the buffer to 0, with its pending target discarded.
REQ-017 Outputs SHALL be glitch-free registered values except npc and link.

Structure
REQ-018 The state encoding, redir_type codes and the default RESET_PC SHALL live in the shared package mips_pkg.
REQ-019 Target computation SHALL be one combinational sub-module, jump_target_gen; state and registers stay in pc_sequencer.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Boot: release rst_n with if_ready=1 -> fetch_valid=0 for one cycle, then pc sequence 0x3000, 0x3004, 0x3008.
- J: redir_npc=0x4000_3010, redir_index=0x0000_100 -> pc=0x4000_0400 next cycle.
- Branch back: redir_npc=0x3010, redir_off=0xFFFC -> pc=0x3000; with redir_off=0x7FFF -> pc=0x0002_300C.
- Hold: JR redir_reg=0x3100 with if_ready=0 for 3 cycles -> pc stays put and a new redirect is ignored; on if_ready=1 -> pc=0x3100.
- Misalign: JR redir_reg=0x3102 -> misalign high for 1 cycle, pc unchanged.
- Reset in S_HOLD: assert rst_n low -> pc=0x3000 immediately, buffer dropped; stall=1 in S_RUN -> pc constant.
